// File: rtl/input_debounce.sv
`default_nettype none
// ============================================================================
// Module      : input_debounce
// Description : Two-channel pushbutton/switch debouncer with 2-flop
//               synchronisers, registered clean levels and rise/fall pulses.
//               Define DEBOUNCE_EVENT_CNT_EN to build the saturating 8-bit
//               accepted-transition counter (event_cnt port).
// Revision    : 1.0 - initial release
// ============================================================================
module input_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       raw_a,
    input  logic       raw_b,
    output logic       a_clean,
    output logic       b_clean,
    output logic       a_rise,
    output logic       b_rise,
    output logic       a_fall,
    output logic       b_fall
`ifdef DEBOUNCE_EVENT_CNT_EN
    ,
    output logic [7:0] event_cnt
`endif
);

    localparam int c_cnt_w = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    localparam logic [0:0] c_st_stable  = 1'b0;
    localparam logic [0:0] c_st_confirm = 1'b1;

    logic [1:0] w_raw;
    logic [1:0] w_clean;
    logic [1:0] w_rise;
    logic [1:0] w_fall;

    assign w_raw = {raw_b, raw_a};

    for (genvar gi = 0; gi < 2; gi++) begin : g_chan
        logic               r_sync1;
        logic               r_sync2;
        logic [0:0]         r_state;
        logic [c_cnt_w-1:0] r_cnt;
        logic               r_clean;
        logic               r_rise;
        logic               r_fall;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
                r_state <= c_st_stable;
                r_cnt   <= '0;
                r_clean <= 1'b0;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
            end else begin
                r_sync1 <= w_raw[gi];
                r_sync2 <= r_sync1;
                r_rise  <= 1'b0;
                r_fall  <= 1'b0;
                case (r_state)
                    c_st_stable: begin
                        // First mismatching edge already counts as one stable sample.
                        if (r_sync2 != r_clean) begin
                            r_state <= c_st_confirm;
                            r_cnt   <= c_cnt_one;
                        end else begin
                            r_cnt   <= '0;
                        end
                    end
                    default: begin
                        if (r_sync2 == r_clean) begin
                            r_state <= c_st_stable;
                            r_cnt   <= '0;
                        end else if (r_cnt == c_cnt_last) begin
                            r_state <= c_st_stable;
                            r_cnt   <= '0;
                            r_clean <= r_sync2;
                            r_rise  <= r_sync2;
                            r_fall  <= ~r_sync2;
                        end else begin
                            r_cnt   <= r_cnt + c_cnt_one;
                        end
                    end
                endcase
            end
        end

        assign w_clean[gi] = r_clean;
        assign w_rise[gi]  = r_rise;
        assign w_fall[gi]  = r_fall;
    end

    assign a_clean = w_clean[0];
    assign b_clean = w_clean[1];
    assign a_rise  = w_rise[0];
    assign b_rise  = w_rise[1];
    assign a_fall  = w_fall[0];
    assign b_fall  = w_fall[1];

`ifdef DEBOUNCE_EVENT_CNT_EN
    logic [7:0] r_event_cnt;
    logic [8:0] w_cnt_sum;

    // Ninth bit flags overflow so the count saturates rather than wraps.
    assign w_cnt_sum = {1'b0, r_event_cnt} + 9'(w_rise[0]) + 9'(w_fall[0])
                     + 9'(w_rise[1]) + 9'(w_fall[1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_event_cnt <= 8'd0;
        end else if (w_cnt_sum[8]) begin
            r_event_cnt <= 8'hFF;
        end else begin
            r_event_cnt <= w_cnt_sum[7:0];
        end
    end

    assign event_cnt = r_event_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_input_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_input_debounce
// Description : Directed bench for input_debounce (DEBOUNCE_CYCLES = 4) with a
//               pulse scoreboard; event_cnt checks when DEBOUNCE_EVENT_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_input_debounce;

    localparam int c_cycles = 4;
    localparam int c_lat    = c_cycles + 2;   // drive -> pulse, in edges
    localparam int c_k_arise = 0;
    localparam int c_k_afall = 1;
    localparam int c_k_brise = 2;
    localparam int c_k_bfall = 3;

    logic clk;
    logic rst_n;
    logic raw_a;
    logic raw_b;
    logic a_clean;
    logic b_clean;
    logic a_rise;
    logic b_rise;
    logic a_fall;
    logic b_fall;
`ifdef DEBOUNCE_EVENT_CNT_EN
    logic [7:0] event_cnt;
    int         exp_cnt;
`endif

    typedef struct {
        int cyc;
        int kind;
    } exp_t;

    exp_t q[$];
    int   cyc;
    int   checks;
    int   errors;
    int   e0;
    int   n_toggle;

    input_debounce #(.DEBOUNCE_CYCLES(c_cycles)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .raw_a   (raw_a),
        .raw_b   (raw_b),
        .a_clean (a_clean),
        .b_clean (b_clean),
        .a_rise  (a_rise),
        .b_rise  (b_rise),
        .a_fall  (a_fall),
        .b_fall  (b_fall)
`ifdef DEBOUNCE_EVENT_CNT_EN
        ,
        .event_cnt (event_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic push(input int c, input int k);
        exp_t e;
        e.cyc  = c;
        e.kind = k;
        q.push_back(e);
    endtask

    // Scoreboard: every pulse must match the oldest expected entry exactly.
    always begin
        logic [3:0] pulses;
        logic       ok;
        @(posedge clk);
        #1;
        pulses = {b_fall, b_rise, a_fall, a_rise};
        if (q.size() > 0) begin
            checks++;
            assert (q[0].cyc >= cyc) else begin
                errors++;
                $error("FAIL missing_pulse kind=%0d observed=none expected_cyc=%0d now=%0d",
                       q[0].kind, q[0].cyc, cyc);
                void'(q.pop_front());
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (pulses[k]) begin
                ok = (q.size() > 0) && (q[0].cyc == cyc) && (q[0].kind == k);
                checks++;
                assert (ok === 1'b1) else begin
                    errors++;
                    $error("FAIL pulse kind=%0d cyc=%0d observed=1 expected=%0s",
                           k, cyc, (q.size() > 0) ? "other_or_later" : "none");
                end
                if (ok) void'(q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        raw_a  = 1'b0;
        raw_b  = 1'b0;
        tick(2);
        chk("rst_a_clean", {7'd0, a_clean}, 8'd0);
        chk("rst_b_clean", {7'd0, b_clean}, 8'd0);
        chk("rst_pulses", {4'd0, a_rise, a_fall, b_rise, b_fall}, 8'd0);
`ifdef DEBOUNCE_EVENT_CNT_EN
        chk("rst_event_cnt", event_cnt, 8'd0);
`endif

        // Held-high input across reset release: full qualification.
        raw_a = 1'b1;
        tick(1);
        rst_n = 1'b1;
        e0 = cyc;
        push(e0 + c_lat, c_k_arise);
        tick(c_lat - 1);
        chk("rel_a_clean_early", {7'd0, a_clean}, 8'd0);
        tick(1);
        chk("rel_a_clean", {7'd0, a_clean}, 8'd1);
        chk("rel_a_rise", {7'd0, a_rise}, 8'd1);
        tick(1);
        chk("rel_a_rise_1cyc", {7'd0, a_rise}, 8'd0);

        // Short glitch on B is rejected.
        raw_b = 1'b1;
        tick(3);
        raw_b = 1'b0;
        tick(3);
        chk("glitch_b_clean_mid", {7'd0, b_clean}, 8'd0);
        tick(6);
        chk("glitch_b_clean", {7'd0, b_clean}, 8'd0);

        // Fall on A, then bouncing with 2-cycle segments, then settle high.
        raw_a = 1'b0;
        push(cyc + c_lat, c_k_afall);
        tick(c_lat + 2);
        chk("fall_a_clean", {7'd0, a_clean}, 8'd0);
        for (int i = 0; i < 10; i++) begin
            raw_a = (i % 2 == 0);
            tick(2);
        end
        chk("bounce_a_clean", {7'd0, a_clean}, 8'd0);
        raw_a = 1'b1;
        e0 = cyc;
        push(e0 + c_lat, c_k_arise);
        tick(c_lat - 1);
        chk("bounce_settle_early", {7'd0, a_clean}, 8'd0);
        tick(1);
        chk("bounce_settle_clean", {7'd0, a_clean}, 8'd1);
        tick(2);

        // Reset mid-CONFIRM on B (counter = 2) while A is clean high.
        raw_b = 1'b1;
        tick(4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_a_clean", {7'd0, a_clean}, 8'd0);
        chk("async_rst_b_clean", {7'd0, b_clean}, 8'd0);
        chk("async_rst_pulses", {4'd0, a_rise, a_fall, b_rise, b_fall}, 8'd0);
`ifdef DEBOUNCE_EVENT_CNT_EN
        chk("async_rst_event_cnt", event_cnt, 8'd0);
`endif
        tick(2);
        rst_n = 1'b1;
        e0 = cyc;
        push(e0 + c_lat, c_k_arise);
        push(e0 + c_lat, c_k_brise);
        tick(c_lat - 1);
        chk("requal_early", {6'd0, b_clean, a_clean}, 8'd0);
        tick(1);
        chk("requal_clean", {6'd0, b_clean, a_clean}, 8'd3);
        chk("requal_rises", {6'd0, b_rise, a_rise}, 8'd3);
`ifdef DEBOUNCE_EVENT_CNT_EN
        chk("cnt_before_pair", event_cnt, 8'd0);
`endif
        tick(1);
`ifdef DEBOUNCE_EVENT_CNT_EN
        chk("cnt_after_pair", event_cnt, 8'd2);
        exp_cnt = 2;
        n_toggle = 130;
`else
        n_toggle = 6;
`endif

        // Back-to-back accepted transitions on both channels.
        for (int i = 0; i < n_toggle; i++) begin
            raw_a = ~raw_a;
            raw_b = ~raw_b;
            push(cyc + c_lat, raw_a ? c_k_arise : c_k_afall);
            push(cyc + c_lat, raw_b ? c_k_brise : c_k_bfall);
            tick(c_lat + 1);
`ifdef DEBOUNCE_EVENT_CNT_EN
            exp_cnt = (exp_cnt + 2 > 255) ? 255 : exp_cnt + 2;
            chk("event_cnt_sat", event_cnt, 8'(exp_cnt));
`endif
        end
        chk("toggle_clean", {6'd0, b_clean, a_clean}, {6'd0, raw_b, raw_a});
        tick(10);
`ifdef DEBOUNCE_EVENT_CNT_EN
        chk("event_cnt_hold", event_cnt, 8'd255);
`endif
        chk("queue_empty", 8'(q.size()), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/input_debounce.md
INPUT_DEBOUNCE -- requirements
Module: input_debounce

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 16, number of consecutive stable synchronised samples required to accept a level change; legal range 2..65535.
REQ-002 Port: clk  input  1  single clock; all state is updated on the rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 Port: raw_a  input  1  unsynchronised level from pushbutton/switch A.
REQ-005 Port: raw_b  input  1  unsynchronised level from pushbutton/switch B.
REQ-006 Port: a_clean  output  1  debounced level of A, registered; drives operand a of the downstream two-input gate stage.
REQ-007 Port: b_clean  output  1  debounced level of B, registered; drives operand b of the downstream two-input gate stage.
REQ-008 Port: a_rise / b_rise  output  1 each  single-cycle pulse on an accepted 0->1 transition of the matching clean output.
REQ-009 Port: a_fall / b_fall  output  1 each  single-cycle pulse on an accepted 1->0 transition of the matching clean output.
REQ-010 Port: event_cnt  output  8  accepted-transition count; present only per REQ-026.

Function
REQ-011 Each raw input SHALL pass through a 2-flop synchroniser (sync1, sync2) before any other use.
REQ-012 Channels A and B SHALL be identical and fully independent, each with its own counter and FSM.
REQ-013 Per-channel FSM states SHALL be STABLE and CONFIRM.
- STABLE: sync2 == clean; counter held at 0.
- STABLE -> CONFIRM: when sync2 != clean.
- CONFIRM -> STABLE (abort, clean unchanged, counter cleared): when sync2 == clean.
- CONFIRM -> STABLE (accept): when the counter reaches DEBOUNCE_CYCLES-1 while sync2 != clean; on the same edge clean <= sync2 and the counter clears.
REQ-014 The counter SHALL increment once per edge in which sync2 != clean and SHALL be sized as ceil(log2(DEBOUNCE_CYCLES)) bits, minimum 1 bit.
REQ-015 A raw level first sampled into sync1 at edge N and held steady SHALL change clean at edge N+DEBOUNCE_CYCLES+1.
REQ-016 A raw pulse or glitch whose synchronised width is shorter than DEBOUNCE_CYCLES cycles SHALL produce no change on clean and no pulse outputs.
REQ-017 The rise/fall pulses SHALL be registered, SHALL assert on the same edge that clean changes, and SHALL be high for exactly one cycle.
REQ-018 Rise and fall for the same channel SHALL never be high in the same cycle.
REQ-019 Simultaneous accepted transitions on A and B SHALL both be reported in the same cycle, with no priority between channels.
REQ-020 Bounce during CONFIRM SHALL restart qualification from 0 on the next mismatch; there is no partial-credit accumulation.

Reset
REQ-021 While rst_n = 0: sync flops, counters, clean outputs, pulse outputs and event_cnt SHALL all be 0, and both FSMs SHALL be in STABLE.
REQ-022 Assertion of reset SHALL take effect immediately, without a clock edge, and SHALL abort any in-progress CONFIRM.
REQ-023 After reset release with a raw input held high, clean SHALL rise only after full qualification per REQ-015 (first sampling edge = first edge after release).
REQ-024 No pulse output SHALL assert as a direct result of reset assertion or release.

Configuration
REQ-025 Macro DEBOUNCE_EVENT_CNT_EN SHALL select whether the event counter is built.
REQ-026 With DEBOUNCE_EVENT_CNT_EN defined:
- event_cnt is present and increments by (number of rise/fall pulses high this cycle), i.e. 0, 1 or 2.
- event_cnt saturates at 255 and never wraps; 254 + 2 SHALL give 255.
REQ-027 Without DEBOUNCE_EVENT_CNT_EN: the event_cnt port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (DEBOUNCE_CYCLES = 4 unless stated)
REQ-028 Reset with raw_a = 1 held, release, then edge 1 samples -> a_clean rises at edge 6, a_rise high for exactly that one cycle, no a_fall.
REQ-029 raw_b high for 3 cycles, then low -> b_clean stays 0, and b_rise/b_fall stay 0 throughout.
REQ-030 raw_a toggles every 2 cycles for 20 cycles, then holds 1 -> a_clean rises exactly 5 edges after the final sampling edge, with a single a_rise.
REQ-031 raw_a and raw_b both go 1 on the same edge -> a_rise and b_rise pulse in the same cycle, and event_cnt goes 0 -> 2.
REQ-032 rst_n pulled low mid-CONFIRM (counter = 2) -> all outputs 0 immediately, and requalification takes the full 5 edges after release.
REQ-033 With DEBOUNCE_EVENT_CNT_EN, drive 130 accepted transitions on each channel -> event_cnt reads 255, holds at 255, never 0; build without the macro compiles and passes REQ-028..REQ-032.
